alu_nibble_seq: RTL and testbench
=================================

Name: alu_nibble_seq

Overview:
- Multi-cycle WIDTH-bit ALU built on one `alu_slice` instance, one nibble per cycle, LSB nibble first.
- Drives slice inputs A/B/OP/C_IN and consumes slice outputs OUT[3:0], prop, gen and zero.
- Ripples carry from prop/gen and accumulates the result word and flags.
- Sits between the control sequencer (START/DONE handshake) and the register file.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 and ≥ 8.
- NIBBLES, WIDTH/4, derived localparam; not overridable.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous active-high reset.
- START  in  1  request a new operation; sampled only when not BUSY.
- A  in  WIDTH  operand A; latched on accepted START.
- B  in  WIDTH  operand B; latched on accepted START.
- OP  in  3  ALU op, `common::ALU_*` encoding; latched.
- C_IN  in  1  carry-in for ADD/SUB (SUB: 1 = no borrow); latched.
- BUSY  out  1  high while nibbles are being processed.
- DONE  out  1  one-cycle pulse when the result is valid.
- OUT  out  WIDTH  result word; held until the next accepted START.
- C_OUT  out  1  final carry (ADD/SUB); 0 for logic ops and NOPs.
- ZERO  out  1  OUT == 0.
- V  out  1  signed overflow (see Optional Feature).

Clocking and reset:
- One clock, CLK.
- Reset RST is synchronous and active-high.

Behaviour:
- States: IDLE, RUN, FIN.
- Reset values:
  - state=IDLE.
  - BUSY=0, DONE=0, OUT=0, C_OUT=0, ZERO=0, V=0.
  - Nibble index=0, carry register=0.
- IDLE/FIN with START=1:
  - Latch A, B, OP.
  - Carry register = C_IN for ADD/SUB, else 0.
  - Index=0, zero accumulator=1, OUT cleared.
  - Next state RUN.
- RUN, each cycle (slice read is combinational):
  - Slice gets A_l[4i+:4], B_l[4i+:4], OP_l, carry register.
  - OUT[4i+:4] <= slice OUT[3:0].
  - carry <= gen | (prop & carry).
  - zero_acc <= zero_acc & slice zero.
  - index <= index+1.
- RUN, when index == NIBBLES-1:
  - Next state FIN.
  - C_OUT <= new carry for ADD/SUB, else 0.
  - ZERO <= final zero_acc.
- FIN: DONE=1 for exactly one cycle; BUSY=0; then IDLE.
  - START in FIN is accepted identically to IDLE (back-to-back operations).
- Latency: START accepted at edge t; DONE high in cycle t+NIBBLES+1.
- BUSY is high exactly NIBBLES cycles.
- START while BUSY is ignored; it is neither queued nor flagged.
- Latched operands are used throughout. Changes to A/B/OP/C_IN during RUN have no effect.
- NOP0/NOP1 run the full sequence: OUT=0, ZERO=1, C_OUT=0.
- OP outside the defined encodings cannot occur (3-bit OP is fully decoded by the `common` package).
- Outputs during RUN:
  - OUT is partially updated and undefined to consumers.
  - ZERO/C_OUT/V keep their previous values until FIN.
- Reset mid-RUN: immediate return to reset values next edge; no DONE pulse.
- Index is clog2(NIBBLES) wide and never wraps past NIBBLES-1.

Optional Feature:
- Macro ALU_NIBBLE_SEQ_OVERFLOW_EN.
- When defined: at the last nibble, V <= (OP==ADD) ? (A_l[MSB]==B_l[MSB] && OUT[MSB]!=A_l[MSB]) : (OP==SUB) ? (A_l[MSB]!=B_l[MSB] && OUT[MSB]!=A_l[MSB]) : 0.
- V is updated alongside ZERO/C_OUT and held.
- When undefined: V is tied to 0 and no overflow logic is synthesised. The port remains so instantiations are identical.

Decomposition:
- Shared `common` package:
  - ALU_ADD/SUB/AND/OR/XOR/NOT/NOP0/NOP1 op encodings.
  - Sequencer state typedef (IDLE, RUN, FIN).
  - Slice output bit-position constants (OUT 3:0, PROP 4, GEN 5, ZERO 6).
- One natural sub-module: the existing `alu_slice`, instantiated once.
- The carry/zero accumulation stays inline.

Test Plan (WIDTH=32, so DONE is 9 cycles after START):
- ADD, A=0x0000FFFF, B=0x00000001, C_IN=0 -> OUT=0x00010000, C_OUT=0, ZERO=0, V=0; DONE exactly at t+9.
- ADD, A=0xFFFFFFFF, B=0x00000001, C_IN=0 -> OUT=0, C_OUT=1, ZERO=1, V=0.
- SUB, A=0x80000000, B=1, C_IN=1 -> OUT=0x7FFFFFFF, C_OUT=1, ZERO=0, V=1 with ALU_NIBBLE_SEQ_OVERFLOW_EN (0 without).
- XOR, A=0x12345678, B=0x12345678 -> OUT=0, ZERO=1, C_OUT=0. Then START pulsed during RUN -> ignored; only one DONE.
- RST asserted at cycle t+4 of an ADD -> next cycle BUSY=0, OUT=0, no DONE. A new START afterwards completes normally.
- Back-to-back: START held high through FIN -> second operation accepted in FIN; DONE pulses 9 cycles apart with correct independent results.

Source files
------------

// File: rtl/common.sv
// Shared definitions for the nibble-serial ALU: op codes,
// sequencer states and slice result bit positions.
package common;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_NOT  = 3'd5;
  localparam logic [2:0] ALU_NOP0 = 3'd6;
  localparam logic [2:0] ALU_NOP1 = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } seq_state_e;

  localparam int SL_OUT_LSB = 0;
  localparam int SL_OUT_MSB = 3;
  localparam int SL_PROP    = 4;
  localparam int SL_GEN     = 5;
  localparam int SL_ZERO    = 6;
  localparam int SL_W       = 7;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// 4-bit ALU slice: a, b, op, c_in in; res out packs
// result[3:0], group propagate, group generate and zero.
module alu_slice
  import common::*;
(
  input  logic [3:0]      a,
  input  logic [3:0]      b,
  input  logic [2:0]      op,
  input  logic            c_in,
  output logic [SL_W-1:0] res
);

  logic [3:0] b_eff;
  logic [4:0] sum0;
  logic [3:0] o;
  logic       p;
  logic       g;

  always_comb begin
    b_eff = (op == ALU_SUB) ? ~b : b;
    sum0  = {1'b0, a} + {1'b0, b_eff};
    o = 4'h0;
    p = 1'b0;
    g = 1'b0;
    unique case (1'b1)
      (op == ALU_ADD),
      (op == ALU_SUB): begin
        o = sum0[3:0] + {3'b000, c_in};
        // carry out = g | (p & c_in)
        g = sum0[4];
        p = (sum0[3:0] == 4'hF);
      end
      (op == ALU_AND): o = a & b;
      (op == ALU_OR):  o = a | b;
      (op == ALU_XOR): o = a ^ b;
      (op == ALU_NOT): o = ~a;
      (op == ALU_NOP0),
      (op == ALU_NOP1): o = 4'h0;
      default:          o = 4'h0;
    endcase
    res = '0;
    res[SL_OUT_MSB:SL_OUT_LSB] = o;
    res[SL_PROP] = p;
    res[SL_GEN]  = g;
    res[SL_ZERO] = (o == 4'h0);
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Multi-cycle ALU: one alu_slice reused per nibble, LSB first.
// Ports: CLK, RST (sync, high), START/BUSY/DONE handshake,
// A, B, OP, C_IN operands; OUT, C_OUT, ZERO, V results.
// Macro ALU_NIBBLE_SEQ_OVERFLOW_EN enables the V flag.
module alu_nibble_seq
  import common::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             C_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] OUT,
  output logic             C_OUT,
  output logic             ZERO,
  output logic             V
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("alu_nibble_seq: bad WIDTH");
  end

  seq_state_e state_q;
  seq_state_e state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] out_q;
  logic [2:0]       op_q;
  logic             carry_q;
  logic             zacc_q;
  logic [IDX_W-1:0] idx_q;
  logic             c_out_q;
  logic             zero_q;

  logic [SL_W-1:0]  sl;
  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  logic             carry_n;
  logic             last;
  logic             accept;

  assign accept = START && (state_q != RUN);
  assign last = (state_q == RUN)
             && (idx_q == IDX_W'(NIBBLES - 1));

  assign sl_a = 4'(a_q >> {idx_q, 2'b00});
  assign sl_b = 4'(b_q >> {idx_q, 2'b00});

  alu_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .op   (op_q),
    .c_in (carry_q),
    .res  (sl)
  );

  assign carry_n = sl[SL_GEN] | (sl[SL_PROP] & carry_q);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) state_d = RUN;
      end
      RUN: begin
        BUSY = 1'b1;
        if (last) state_d = FIN;
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = START ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      idx_q   <= '0;
      c_out_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= B;
      op_q    <= OP;
      carry_q <= is_arith(OP) ? C_IN : 1'b0;
      zacc_q  <= 1'b1;
      idx_q   <= '0;
      out_q   <= '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx_q == IDX_W'(i))
          out_q[4*i +: 4] <= sl[SL_OUT_MSB:SL_OUT_LSB];
      end
      carry_q <= carry_n;
      zacc_q  <= zacc_q & sl[SL_ZERO];
      // index parks on the last nibble instead of wrapping
      if (!last) idx_q <= idx_q + 1'b1;
      if (last) begin
        c_out_q <= is_arith(op_q) & carry_n;
        zero_q  <= zacc_q & sl[SL_ZERO];
      end
    end
  end

`ifdef ALU_NIBBLE_SEQ_OVERFLOW_EN
  logic v_q;
  logic v_n;
  logic a_msb;
  logic b_msb;
  logic r_msb;

  assign a_msb = a_q[WIDTH-1];
  assign b_msb = b_q[WIDTH-1];
  // last slice result nibble holds the result MSB
  assign r_msb = sl[SL_OUT_MSB];

  always_comb begin
    v_n = 1'b0;
    unique case (1'b1)
      (op_q == ALU_ADD):
        v_n = (a_msb == b_msb) && (r_msb != a_msb);
      (op_q == ALU_SUB):
        v_n = (a_msb != b_msb) && (r_msb != a_msb);
      default: v_n = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST)       v_q <= 1'b0;
    else if (last) v_q <= v_n;
  end

  assign V = v_q;
`else
  assign V = 1'b0;
`endif

  assign OUT   = out_q;
  assign C_OUT = c_out_q;
  assign ZERO  = zero_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq (WIDTH=32):
// directed cases, reset mid-run, back-to-back, random ops.
module tb_alu_nibble_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        c_out;
  logic        zero;
  logic        v;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;

  alu_nibble_seq #(.WIDTH(32)) dut (
    .CLK   (clk),
    .RST   (rst),
    .START (start),
    .A     (a),
    .B     (b),
    .OP    (op),
    .C_IN  (c_in),
    .BUSY  (busy),
    .DONE  (done),
    .OUT   (out),
    .C_OUT (c_out),
    .ZERO  (zero),
    .V     (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // returns {v, zero, c_out, result}
  function automatic logic [34:0] model(
      input logic [2:0] o, input logic [31:0] x,
      input logic [31:0] y, input logic ci);
    logic [32:0] s;
    logic [31:0] r;
    logic c;
    logic ov;
    s = 33'd0;
    c = 1'b0;
    ov = 1'b0;
    case (o)
      3'd0: begin
        s = {1'b0, x} + {1'b0, y} + 33'(ci);
        ov = (x[31] == y[31]) && (s[31] != x[31]);
      end
      3'd1: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'(ci);
        ov = (x[31] != y[31]) && (s[31] != x[31]);
      end
      3'd2: s = {1'b0, x & y};
      3'd3: s = {1'b0, x | y};
      3'd4: s = {1'b0, x ^ y};
      3'd5: s = {1'b0, ~x};
      default: s = 33'd0;
    endcase
    r = s[31:0];
    c = s[32];
`ifndef ALU_NIBBLE_SEQ_OVERFLOW_EN
    ov = 1'b0;
`endif
    return {ov, (r == 32'd0), c, r};
  endfunction

  task automatic wait_done(input string tag, input bit poke,
                           output int n);
    n = 1;
    while (!done && n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (poke && n == 3) begin
        start = 1'b1;
        a = $urandom;
        b = $urandom;
        op = 3'($urandom_range(0, 7));
        c_in = ~c_in;
      end
      if (poke && n == 5) start = 1'b0;
    end
    chk({tag, "_lat"}, 64'(n), 64'd9);
  endtask

  task automatic chk_res(input string tag, input logic [34:0] e);
    chk({tag, "_out"}, 64'(out), 64'(e[31:0]));
    chk({tag, "_cout"}, 64'(c_out), 64'(e[32]));
    chk({tag, "_zero"}, 64'(zero), 64'(e[33]));
    chk({tag, "_v"}, 64'(v), 64'(e[34]));
  endtask

  task automatic do_op(input string tag, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input bit poke);
    logic [34:0] e;
    int n;
    int d0;
    e = model(o, x, y, ci);
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    c_in = ci;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~x;
    b = $urandom;
    d0 = done_cnt;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(tag, poke, n);
    chk_res(tag, e);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_ndone"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int n;
    int d0;
    logic [34:0] e1;
    logic [34:0] e2;
    logic [2:0] ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    c_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_flags", 64'({c_out, zero, v}), 64'd0);
    rst = 1'b0;

    do_op("add1", 3'd0, 32'h0000FFFF, 32'h1, 1'b0, 1'b0);
    do_op("add2", 3'd0, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0);
    do_op("sub1", 3'd1, 32'h80000000, 32'h1, 1'b1, 1'b0);
    do_op("xor1", 3'd4, 32'h12345678, 32'h12345678, 1'b0, 1'b1);
    do_op("nop0", 3'd6, 32'hDEADBEEF, 32'h1, 1'b1, 1'b0);
    do_op("nop1", 3'd7, 32'h1, 32'h2, 1'b0, 1'b0);

    // reset in the middle of an ADD
    @(negedge clk);
    op = 3'd0;
    a = 32'h0F0F0F0F;
    b = 32'h01010101;
    c_in = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_out", 64'(out), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("mrst_nodone", 64'(done_cnt - d0), 64'd0);
    do_op("post_rst", 3'd0, 32'h0F0F0F0F, 32'h01010101, 1'b1,
          1'b0);

    // back-to-back: START held through FIN
    e1 = model(3'd1, 32'h00001000, 32'h00002000, 1'b1);
    e2 = model(3'd0, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    @(negedge clk);
    op = 3'd1;
    a = 32'h00001000;
    b = 32'h00002000;
    c_in = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    op = 3'd0;
    a = 32'h7FFFFFFF;
    b = 32'h00000001;
    c_in = 1'b0;
    wait_done("b2b1", 1'b0, n);
    chk_res("b2b1", e1);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b2_busy", 64'(busy), 64'd1);
    wait_done("b2b2", 1'b0, n);
    chk_res("b2b2", e2);
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 5 == 0) ? ra : $urandom;
      if (i % 7 == 3) rb = ~ra;
      do_op($sformatf("rnd%0d", i), ro, ra, rb,
            1'($urandom_range(0, 1)), 1'(i % 3 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
